// File: rtl/systolic_array_stream.sv
// Weight-stationary ROWS x COLS systolic matrix-vector engine with skew/deskew,
// valid/ready activation stream, drained weight reload and saturation. Optional ReLU: RELU_EN.
module systolic_array_stream #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int ACC_W = 2*WIDTH + $clog2(ROWS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS*WIDTH-1:0]         in_vec,
  input  logic                          load_req,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [$clog2(ROWS)-1:0]       w_row,
  input  logic [COLS*WIDTH-1:0]         w_data,
  input  logic                          w_last,
  output logic                          out_valid,
  output logic [COLS*WIDTH-1:0]         out_vec,
  output logic                          busy
);

  localparam int LAT    = ROWS + COLS;
  localparam int CNT_W  = $clog2(LAT + 1);
  localparam int PROD_W = 2 * WIDTH;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, LOAD = 2'd3} state_t;

  state_t                    state_r, state_next_s;
  logic                      in_ready_r, w_ready_r, busy_r, out_valid_r;
  logic                      accept_s;
  logic [CNT_W-1:0]          cnt_r, cnt_next_s;
  logic [LAT-1:0]            vpipe_r;
  logic [COLS*WIDTH-1:0]     out_vec_r, res_s;
  logic signed [WIDTH-1:0]   w_r     [ROWS][COLS];
  logic signed [WIDTH-1:0]   a_s     [ROWS][COLS];
  logic signed [ACC_W-1:0]   p_s     [ROWS][COLS];
  logic signed [WIDTH-1:0]   row_in_s[ROWS];

  function automatic logic signed [WIDTH-1:0] sat_fn(input logic signed [ACC_W-1:0] acc);
    if (acc > SAT_MAX) begin
      return SAT_MAX[WIDTH-1:0];
    end else if (acc < SAT_MIN) begin
      return SAT_MIN[WIDTH-1:0];
    end else begin
      return acc[WIDTH-1:0];
    end
  endfunction

  function automatic logic signed [WIDTH-1:0] relu_fn(input logic signed [WIDTH-1:0] v);
`ifdef RELU_EN
    return v[WIDTH-1] ? {WIDTH{1'b0}} : v;
`else
    return v;
`endif
  endfunction

  assign accept_s   = in_valid && in_ready_r;
  assign cnt_next_s = cnt_r + CNT_W'(accept_s) - CNT_W'(out_valid_r);

  // Next-state decode; weight reload only starts once the array is empty.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_req) begin
          state_next_s = accept_s ? DRAIN : LOAD;
        end else if (accept_s) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (load_req) begin
          state_next_s = DRAIN;
        end else if (cnt_next_s == {CNT_W{1'b0}} && !accept_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        if (cnt_next_s == {CNT_W{1'b0}}) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = DRAIN;
        end
      end
      LOAD: begin
        if (w_valid && w_last) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = LOAD;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register with registered handshake and busy outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
      w_ready_r  <= 1'b0;
      busy_r     <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= (state_next_s == IDLE) || (state_next_s == RUN);
      w_ready_r  <= (state_next_s == LOAD);
      busy_r     <= (state_next_s != IDLE) || (cnt_next_s != {CNT_W{1'b0}});
      cnt_r      <= cnt_next_s;
    end
  end

  // Weight store; only written in LOAD, when nothing is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          w_r[r][c] <= {WIDTH{1'b0}};
    end else if (state_r == LOAD && w_valid) begin
      for (int c = 0; c < COLS; c++)
        w_r[w_row][c] <= w_data[c*WIDTH +: WIDTH];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic signed [WIDTH-1:0] sk_r [0:r];
    // Row r sees its element r cycles late; idle slots carry zeros.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k <= r; k++) sk_r[k] <= {WIDTH{1'b0}};
      end else begin
        sk_r[0] <= accept_s ? in_vec[r*WIDTH +: WIDTH] : {WIDTH{1'b0}};
        for (int k = 1; k <= r; k++) sk_r[k] <= sk_r[k-1];
      end
    end
    assign row_in_s[r] = sk_r[r];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic signed [WIDTH-1:0]  a_left_s, a_r;
      logic signed [ACC_W-1:0]  p_up_s, p_r;
      logic signed [PROD_W-1:0] prod_s;
      if (c == 0) begin : g_ain
        assign a_left_s = row_in_s[r];
      end else begin : g_ain
        assign a_left_s = a_s[r][c-1];
      end
      if (r == 0) begin : g_pin
        assign p_up_s = {ACC_W{1'b0}};
      end else begin : g_pin
        assign p_up_s = p_s[r-1][c];
      end
      assign prod_s = PROD_W'(a_left_s) * PROD_W'(w_r[r][c]);
      // Activation moves right, partial sum moves down.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_r <= {WIDTH{1'b0}};
          p_r <= {ACC_W{1'b0}};
        end else begin
          a_r <= a_left_s;
          p_r <= p_up_s + ACC_W'(prod_s);
        end
      end
      assign a_s[r][c] = a_r;
      assign p_s[r][c] = p_r;
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int D = COLS - 1 - c;
    logic signed [ACC_W-1:0] col_s;
    if (D == 0) begin : g_d
      assign col_s = p_s[ROWS-1][c];
    end else begin : g_d
      logic signed [ACC_W-1:0] dk_r [0:D-1];
      // Realign column c with the last column.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < D; k++) dk_r[k] <= {ACC_W{1'b0}};
        end else begin
          dk_r[0] <= p_s[ROWS-1][c];
          for (int k = 1; k < D; k++) dk_r[k] <= dk_r[k-1];
        end
      end
      assign col_s = dk_r[D-1];
    end
    assign res_s[c*WIDTH +: WIDTH] = relu_fn(sat_fn(col_s));
  end

  // Valid pipeline and output register; out_vec holds between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe_r     <= {LAT{1'b0}};
      out_valid_r <= 1'b0;
      out_vec_r   <= {(COLS*WIDTH){1'b0}};
    end else begin
      vpipe_r     <= {vpipe_r[LAT-2:0], accept_s};
      out_valid_r <= vpipe_r[LAT-1];
      if (vpipe_r[LAT-1]) out_vec_r <= res_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign w_ready   = w_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_vec   = out_vec_r;

endmodule

// File: tb/tb_systolic_array_stream.sv
// Directed self-checking bench for systolic_array_stream (4x4, WIDTH=16).
module tb_systolic_array_stream;
  localparam int LAT = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, load_req = 1'b0, w_valid = 1'b0, w_last = 1'b0;
  logic [1:0]  w_row = 2'd0;
  logic [63:0] in_vec = 64'd0, w_data = 64'd0;
  logic        in_ready, w_ready, out_valid, busy;
  logic [63:0] out_vec;
  int          checks = 0, failures = 0;
  logic        flag;

  systolic_array_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .load_req(load_req), .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
    .w_data(w_data), .w_last(w_last), .out_valid(out_valid), .out_vec(out_vec), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] v4(input int e0, input int e1, input int e2, input int e3);
    logic [15:0] a, b, c, d;
    a = e0[15:0]; b = e1[15:0]; c = e2[15:0]; d = e3[15:0];
    return {d, c, b, a};
  endfunction

  function automatic int rl(input int x);
`ifdef RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int row, input logic [63:0] data, input logic last);
    w_valid = 1'b1; w_row = row[1:0]; w_data = data; w_last = last;
    tick();
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic load_full(input logic [63:0] r0, input logic [63:0] r1,
                           input logic [63:0] r2, input logic [63:0] r3);
    int n;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    n = 0;
    while (!w_ready && n < 40) begin
      tick();
      n++;
    end
    chk("load_w_ready", {63'd0, w_ready}, 64'd1);
    beat(0, r0, 1'b0); beat(1, r1, 1'b0); beat(2, r2, 1'b0); beat(3, r3, 1'b1);
  endtask

  task automatic send(input logic [63:0] v);
    chk("send_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_vec = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [63:0] exp);
    repeat (LAT) tick();
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_data"}, out_vec, exp);
  endtask

  initial begin
    // reset state
    #2 rst = 1'b0;
    tick(); tick();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_w_ready", {63'd0, w_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_vec", out_vec, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b1;
    tick();
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

    // identity, exact latency, single pulse
    load_full(v4(1,0,0,0), v4(0,1,0,0), v4(0,0,1,0), v4(0,0,0,1));
    send(v4(1,2,3,4));
    flag = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      tick();
      if (out_valid) flag = 1'b1;
    end
    chk("id_early_valid", {63'd0, flag}, 64'd0);
    tick();
    chk("id_valid", {63'd0, out_valid}, 64'd1);
    chk("id_data", out_vec, v4(1,2,3,4));
    tick();
    chk("id_one_pulse", {63'd0, out_valid}, 64'd0);
    chk("id_hold", out_vec, v4(1,2,3,4));
    chk("id_busy_done", {63'd0, busy}, 64'd0);

    // back-to-back with W[r][c] = r+1
    load_full(v4(1,1,1,1), v4(2,2,2,2), v4(3,3,3,3), v4(4,4,4,4));
    send(v4(1,1,1,1)); send(v4(2,0,0,0)); send(v4(0,0,0,-1));
    repeat (LAT - 2) tick();
    chk("b2b0_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b0_data", out_vec, v4(10,10,10,10));
    tick();
    chk("b2b1_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b1_data", out_vec, v4(2,2,2,2));
    tick();
    chk("b2b2_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b2_data", out_vec, v4(rl(-4),rl(-4),rl(-4),rl(-4)));
    tick();
    chk("b2b_end", {63'd0, out_valid}, 64'd0);

    // saturation both ways
    load_full(v4(32767,32767,32767,32767), v4(32767,32767,32767,32767),
              v4(32767,32767,32767,32767), v4(32767,32767,32767,32767));
    send(v4(32767,32767,32767,32767));
    wait_out("sat_pos", v4(32767,32767,32767,32767));
    send(v4(-32768,-32768,-32768,-32768));
    wait_out("sat_neg", v4(rl(-32768),rl(-32768),rl(-32768),rl(-32768)));

    // drain on reload
    load_full(v4(1,0,0,0), v4(0,1,0,0), v4(0,0,1,0), v4(0,0,0,1));
    send(v4(5,6,7,8));
    chk("drn_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_vec = v4(3,0,0,-2); load_req = 1'b1;
    tick();
    in_valid = 1'b0; load_req = 1'b0;
    chk("drn_busy", {63'd0, busy}, 64'd1);
    flag = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (in_ready || w_ready) flag = 1'b1;
      if (k == 8) begin
        chk("drn0_valid", {63'd0, out_valid}, 64'd1);
        chk("drn0_data", out_vec, v4(5,6,7,8));
      end
      if (k == 9) begin
        chk("drn1_valid", {63'd0, out_valid}, 64'd1);
        chk("drn1_data", out_vec, v4(3,0,0,rl(-2)));
      end
      if (k < 9) tick();
    end
    chk("drn_stalled", {63'd0, flag}, 64'd0);
    tick();
    chk("drn_to_load", {63'd0, w_ready}, 64'd1);
    beat(0, v4(2,0,0,0), 1'b0); beat(1, v4(0,2,0,0), 1'b0);
    beat(2, v4(0,0,2,0), 1'b0); beat(3, v4(0,0,0,2), 1'b1);
    send(v4(1,1,1,1));
    wait_out("new_w", v4(2,2,2,2));

    // stray weight beat in IDLE, then partial load of row 2
    w_valid = 1'b1; w_row = 2'd0; w_data = v4(7,7,7,7); w_last = 1'b1;
    tick();
    w_valid = 1'b0; w_last = 1'b0;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("part_w_ready", {63'd0, w_ready}, 64'd1);
    beat(2, v4(9,9,9,9), 1'b1);
    send(v4(0,0,1,0));
    wait_out("part_row2", v4(9,9,9,9));
    send(v4(1,0,0,0));
    wait_out("part_row0", v4(2,0,0,0));

    // reset mid-stream
    send(v4(1,1,1,1)); send(v4(1,2,3,4)); send(v4(4,3,2,1));
    rst = 1'b0;
    #1;
    chk("mid_rst_vec", out_vec, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    flag = 1'b0;
    repeat (12) begin
      if (out_valid) flag = 1'b1;
      tick();
    end
    chk("post_rst_no_valid", {63'd0, flag}, 64'd0);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    send(v4(1,2,3,4));
    wait_out("post_rst_zero_w", 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
